// File: rtl/axi_arb_pkg.sv
// Shared types for the two-master AXI round-robin arbiter: write/read FSM
// state encodings and the width of the optional transaction counters.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_DAT  = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DAT  = 2'd2
  } rd_state_t;

  localparam int STATS_W = 16;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin pick: on a tie the requester that did not win
// last time gets the grant. Purely combinational.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_gnt_idx,
  output logic       o_gnt_vld
);

  always_comb begin
    o_gnt_vld = |i_req;
    o_gnt_idx = 1'b0;
    case (i_req)
      2'b01:   o_gnt_idx = 1'b0;
      2'b10:   o_gnt_idx = 1'b1;
      2'b11:   o_gnt_idx = ~i_last;
      default: o_gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_rr_arbiter.sv
// Two-master round-robin arbiter in front of one single-beat AXI-style slave.
// Write and read paths are arbitrated independently; grant is held until the
// response handshake. Optional per-master counters via AXI_ARB_STATS_EN.
module axi_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  // master 0
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic [LEN_W-1:0]    m0_awlen,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [LEN_W-1:0]    m0_arlen,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  // master 1
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [LEN_W-1:0]    m1_awlen,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [LEN_W-1:0]    m1_arlen,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  // slave
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [LEN_W-1:0]    s_awlen,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [LEN_W-1:0]    s_arlen,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_rvalid,
  output logic                s_rready,
  // status
  output logic                wr_owner,
  output logic                rd_owner,
  output logic                wr_busy,
  output logic                rd_busy
`ifdef AXI_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]  m0_wr_cnt,
  output logic [STATS_W-1:0]  m1_wr_cnt,
  output logic [STATS_W-1:0]  m0_rd_cnt,
  output logic [STATS_W-1:0]  m1_rd_cnt
`endif
);

  // ---------------------------------------------------------------- write path
  wr_state_t             r_wr_state;
  wr_state_t             w_wr_next;
  logic                  r_wr_owner;
  logic                  r_wr_last;
  logic [ADDR_W-1:0]     r_awaddr;
  logic [LEN_W-1:0]      r_awlen;
  logic                  w_wr_gidx;
  logic                  w_wr_gvld;
  logic                  w_wvalid_sel;
  logic [DATA_W-1:0]     w_wdata_sel;
  logic [DATA_W/8-1:0]   w_wstrb_sel;
  logic                  w_bready_sel;
  logic                  w_b_hs;

  rr_pick2 u_wr_pick (
    .i_req     ({m1_awvalid, m0_awvalid}),
    .i_last    (r_wr_last),
    .o_gnt_idx (w_wr_gidx),
    .o_gnt_vld (w_wr_gvld)
  );

  assign w_wvalid_sel = r_wr_owner ? m1_wvalid : m0_wvalid;
  assign w_wdata_sel  = r_wr_owner ? m1_wdata  : m0_wdata;
  assign w_wstrb_sel  = r_wr_owner ? m1_wstrb  : m0_wstrb;
  assign w_bready_sel = r_wr_owner ? m1_bready : m0_bready;
  assign w_b_hs       = (r_wr_state == W_RESP) & s_bvalid & w_bready_sel;

  always_ff @(posedge clk) begin
    if (reset) r_wr_state <= W_IDLE;
    else       r_wr_state <= w_wr_next;
  end

  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      W_IDLE:  if (w_wr_gvld)                  w_wr_next = W_AW;
      W_AW:    if (s_awready)                  w_wr_next = W_DAT;
      W_DAT:   if (w_wvalid_sel && s_wready)   w_wr_next = W_RESP;
      W_RESP:  if (s_bvalid && w_bready_sel)   w_wr_next = W_IDLE;
      default:                                 w_wr_next = W_IDLE;
    endcase
  end

  // The slave re-samples awaddr during the data phase, so it must not follow
  // the master's live bus once the grant is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_owner <= 1'b0;
      r_wr_last  <= 1'b1;
      r_awaddr   <= '0;
      r_awlen    <= '0;
    end else begin
      if (r_wr_state == W_IDLE && w_wr_gvld) begin
        r_wr_owner <= w_wr_gidx;
        r_awaddr   <= w_wr_gidx ? m1_awaddr : m0_awaddr;
        r_awlen    <= w_wr_gidx ? m1_awlen  : m0_awlen;
      end
      if (w_b_hs) r_wr_last <= r_wr_owner;
    end
  end

  always_comb begin
    s_awvalid  = 1'b0;
    m0_awready = 1'b0;
    m1_awready = 1'b0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    m0_wready  = 1'b0;
    m1_wready  = 1'b0;
    m0_bvalid  = 1'b0;
    m1_bvalid  = 1'b0;
    s_bready   = 1'b0;
    case (r_wr_state)
      W_AW: begin
        s_awvalid  = 1'b1;
        m0_awready = s_awready & ~r_wr_owner;
        m1_awready = s_awready &  r_wr_owner;
      end
      W_DAT: begin
        s_wvalid  = w_wvalid_sel;
        s_wdata   = w_wdata_sel;
        s_wstrb   = w_wstrb_sel;
        m0_wready = s_wready & ~r_wr_owner;
        m1_wready = s_wready &  r_wr_owner;
      end
      W_RESP: begin
        m0_bvalid = s_bvalid & ~r_wr_owner;
        m1_bvalid = s_bvalid &  r_wr_owner;
        s_bready  = w_bready_sel;
      end
      default: ;
    endcase
  end

  assign s_awaddr = r_awaddr;
  assign s_awlen  = r_awlen;
  assign wr_owner = r_wr_owner;
  assign wr_busy  = (r_wr_state != W_IDLE);

  // ----------------------------------------------------------------- read path
  rd_state_t             r_rd_state;
  rd_state_t             w_rd_next;
  logic                  r_rd_owner;
  logic                  r_rd_last;
  logic [ADDR_W-1:0]     r_araddr;
  logic [LEN_W-1:0]      r_arlen;
  logic                  w_rd_gidx;
  logic                  w_rd_gvld;
  logic                  w_rready_sel;
  logic                  w_r_hs;

  rr_pick2 u_rd_pick (
    .i_req     ({m1_arvalid, m0_arvalid}),
    .i_last    (r_rd_last),
    .o_gnt_idx (w_rd_gidx),
    .o_gnt_vld (w_rd_gvld)
  );

  assign w_rready_sel = r_rd_owner ? m1_rready : m0_rready;
  assign w_r_hs       = (r_rd_state == R_DAT) & s_rvalid & w_rready_sel;

  always_ff @(posedge clk) begin
    if (reset) r_rd_state <= R_IDLE;
    else       r_rd_state <= w_rd_next;
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_rd_gvld)                 w_rd_next = R_AR;
      R_AR:    if (s_arready)                 w_rd_next = R_DAT;
      R_DAT:   if (s_rvalid && w_rready_sel)  w_rd_next = R_IDLE;
      default:                                w_rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_owner <= 1'b0;
      r_rd_last  <= 1'b1;
      r_araddr   <= '0;
      r_arlen    <= '0;
    end else begin
      if (r_rd_state == R_IDLE && w_rd_gvld) begin
        r_rd_owner <= w_rd_gidx;
        r_araddr   <= w_rd_gidx ? m1_araddr : m0_araddr;
        r_arlen    <= w_rd_gidx ? m1_arlen  : m0_arlen;
      end
      if (w_r_hs) r_rd_last <= r_rd_owner;
    end
  end

  always_comb begin
    s_arvalid  = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    s_rready   = 1'b0;
    case (r_rd_state)
      R_AR: begin
        s_arvalid  = 1'b1;
        m0_arready = s_arready & ~r_rd_owner;
        m1_arready = s_arready &  r_rd_owner;
      end
      R_DAT: begin
        m0_rvalid = s_rvalid & ~r_rd_owner;
        m1_rvalid = s_rvalid &  r_rd_owner;
        s_rready  = w_rready_sel;
      end
      default: ;
    endcase
  end

  assign s_araddr = r_araddr;
  assign s_arlen  = r_arlen;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign rd_owner = r_rd_owner;
  assign rd_busy  = (r_rd_state != R_IDLE);

`ifdef AXI_ARB_STATS_EN
  // ------------------------------------------------------------ stats counters
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_wr_cnt <= '0;
      m1_wr_cnt <= '0;
      m0_rd_cnt <= '0;
      m1_rd_cnt <= '0;
    end else begin
      if (w_b_hs) begin
        if (r_wr_owner) m1_wr_cnt <= m1_wr_cnt + 1'b1;
        else            m0_wr_cnt <= m0_wr_cnt + 1'b1;
      end
      if (w_r_hs) begin
        if (r_rd_owner) m1_rd_cnt <= m1_rd_cnt + 1'b1;
        else            m0_rd_cnt <= m0_rd_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Bench for axi_rr_arbiter: small memory slave model, table of directed
// transactions plus hand-written tie, concurrency and mid-transaction reset.
module tb_axi_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic [31:0] m_awaddr [2];
  logic [7:0]  m_awlen  [2];
  logic [1:0]  m_awvalid, m_awready;
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_wstrb  [2];
  logic [1:0]  m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0] m_araddr [2];
  logic [7:0]  m_arlen  [2];
  logic [1:0]  m_arvalid, m_arready;
  logic [31:0] m_rdata  [2];
  logic [1:0]  m_rvalid, m_rready;

  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [7:0]  s_awlen, s_arlen;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        wr_owner, rd_owner, wr_busy, rd_busy;
`ifdef AXI_ARB_STATS_EN
  logic [15:0] m0_wr_cnt, m1_wr_cnt, m0_rd_cnt, m1_rd_cnt;
`endif

  axi_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
    .clk(clk), .reset(reset),
    .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]), .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
    .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
    .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
    .m0_araddr(m_araddr[0]), .m0_arlen(m_arlen[0]), .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
    .m0_rdata(m_rdata[0]), .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
    .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]), .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
    .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
    .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
    .m1_araddr(m_araddr[1]), .m1_arlen(m_arlen[1]), .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
    .m1_rdata(m_rdata[1]), .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wr_owner(wr_owner), .rd_owner(rd_owner), .wr_busy(wr_busy), .rd_busy(rd_busy)
`ifdef AXI_ARB_STATS_EN
    , .m0_wr_cnt(m0_wr_cnt), .m1_wr_cnt(m1_wr_cnt), .m0_rd_cnt(m0_rd_cnt), .m1_rd_cnt(m1_rd_cnt)
`endif
  );

  // Memory slave: always ready, writes at the address it sees during W,
  // one-cycle registered B and R responses.
  logic [31:0] mem [64];
  logic        r_bvalid, r_rvalid;
  logic [31:0] r_rdata;
  assign s_awready = 1'b1;
  assign s_wready  = 1'b1;
  assign s_arready = 1'b1;
  assign s_bvalid  = r_bvalid;
  assign s_rvalid  = r_rvalid;
  assign s_rdata   = r_rdata;

  always @(posedge clk) begin
    if (reset) begin
      r_bvalid <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      if (s_wvalid && s_wready) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) mem[s_awaddr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        r_bvalid <= 1'b1;
      end else if (r_bvalid && s_bready) begin
        r_bvalid <= 1'b0;
      end
      if (s_arvalid && s_arready) begin
        r_rvalid <= 1'b1;
        r_rdata  <= mem[s_araddr[7:2]];
      end else if (r_rvalid && s_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Non-owners must never see a ready/valid asserted.
  int iso_err = 0;
  always @(negedge clk) begin
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        if ((m_awready[m] | m_wready[m] | m_bvalid[m]) && !(wr_busy && (32'(wr_owner) == m)))
          iso_err <= iso_err + 1;
        if ((m_arready[m] | m_rvalid[m]) && !(rd_busy && (32'(rd_owner) == m)))
          iso_err <= iso_err + 1;
      end
    end
  end

  int tests = 0;
  int fails = 0;
  int exp_wr [2];
  int exp_rd [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_wr(input int m, input logic [31:0] addr, input logic [31:0] data, input int gap,
                       output logic [31:0] seen_addr, output logic seen_owner, output int t_grant,
                       output logic ok);
    logic got;
    ok = 1'b0; seen_addr = '0; seen_owner = 1'b0; t_grant = -1;
    @(posedge clk); #1;
    m_awaddr[m] = addr; m_awlen[m] = 8'd0; m_awvalid[m] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_awready[m]) begin
        seen_addr = s_awaddr; seen_owner = wr_owner; t_grant = cyc; break;
      end
    end
    @(posedge clk); #1;
    m_awvalid[m] = 1'b0;
    m_awaddr[m]  = addr ^ 32'h0000_00FC;
    if (t_grant < 0) return;
    repeat (gap) @(posedge clk);
    #1;
    m_wdata[m] = data; m_wstrb[m] = 4'hF; m_wvalid[m] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_wready[m]) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    m_wvalid[m] = 1'b0;
    if (!got) return;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_bvalid[m]) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_rd(input int m, input logic [31:0] addr,
                       output logic [31:0] seen_addr, output logic seen_owner,
                       output logic [31:0] rdata, output logic ok);
    logic got;
    ok = 1'b0; seen_addr = '0; seen_owner = 1'b0; rdata = '0; got = 1'b0;
    @(posedge clk); #1;
    m_araddr[m] = addr; m_arlen[m] = 8'd0; m_arvalid[m] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_arready[m]) begin
        seen_addr = s_araddr; seen_owner = rd_owner; got = 1'b1; break;
      end
    end
    @(posedge clk); #1;
    m_arvalid[m] = 1'b0;
    m_araddr[m]  = ~addr;
    if (!got) return;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_rvalid[m]) begin rdata = m_rdata[m]; ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          m;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;   // write data, or expected read data
    int          gap;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sa0, sa1, rd0;
    logic        so0, so1, ok0, ok1, seen;
    int          t0, t1;

    vecs[0] = '{0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0};
    vecs[1] = '{0, 1'b0, 32'h10, 32'hDEAD_BEEF, 0};
    vecs[2] = '{1, 1'b1, 32'h20, 32'h1234_5678, 2};
    vecs[3] = '{1, 1'b0, 32'h20, 32'h1234_5678, 0};
    vecs[4] = '{0, 1'b0, 32'h20, 32'h1234_5678, 0};
    vecs[5] = '{1, 1'b1, 32'h44, 32'hCAFE_0044, 0};
    vecs[6] = '{0, 1'b1, 32'h24, 32'h0BAD_F00D, 1};
    vecs[7] = '{1, 1'b0, 32'h24, 32'h0BAD_F00D, 0};

    for (int m = 0; m < 2; m++) begin
      m_awaddr[m] = '0; m_awlen[m] = '0; m_wdata[m] = '0; m_wstrb[m] = '0;
      m_araddr[m] = '0; m_arlen[m] = '0;
      exp_wr[m] = 0; exp_rd[m] = 0;
    end
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0;
    m_bready = 2'b11; m_rready = 2'b11;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_busy",   32'(wr_busy),   32'd0);
    check("rst_rd_busy",   32'(rd_busy),   32'd0);
    check("rst_s_awvalid", 32'(s_awvalid), 32'd0);
    check("rst_s_arvalid", 32'(s_arvalid), 32'd0);
    check("rst_s_awaddr",  s_awaddr,       32'd0);
    check("rst_s_araddr",  s_araddr,       32'd0);
    check("rst_m_bvalid",  32'(m_bvalid),  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Simultaneous requests right after reset: m0 first, then m1; repeat.
    fork
      do_wr(0, 32'h60, 32'h6060_6060, 0, sa0, so0, t0, ok0);
      do_wr(1, 32'h64, 32'h6464_6464, 0, sa1, so1, t1, ok1);
    join
    check("tie1_ok0", 32'(ok0), 32'd1);
    check("tie1_ok1", 32'(ok1), 32'd1);
    check("tie1_m0_first", 32'(t0 < t1), 32'd1);
    check("tie1_m1_addr", sa1, 32'h64);
    if (ok0) exp_wr[0]++;
    if (ok1) exp_wr[1]++;
    fork
      do_wr(0, 32'h68, 32'h6868_6868, 0, sa0, so0, t0, ok0);
      do_wr(1, 32'h6C, 32'h6C6C_6C6C, 0, sa1, so1, t1, ok1);
    join
    check("tie2_m0_first", 32'(t0 < t1), 32'd1);
    if (ok0) exp_wr[0]++;
    if (ok1) exp_wr[1]++;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) begin
        do_wr(vecs[i].m, vecs[i].addr, vecs[i].data, vecs[i].gap, sa0, so0, t0, ok0);
        check($sformatf("vec%0d_wr_done", i), 32'(ok0), 32'd1);
        check($sformatf("vec%0d_s_awaddr", i), sa0, vecs[i].addr);
        check($sformatf("vec%0d_wr_owner", i), 32'(so0), 32'(vecs[i].m));
        if (ok0) exp_wr[vecs[i].m]++;
      end else begin
        do_rd(vecs[i].m, vecs[i].addr, sa0, so0, rd0, ok0);
        check($sformatf("vec%0d_rd_done", i), 32'(ok0), 32'd1);
        check($sformatf("vec%0d_s_araddr", i), sa0, vecs[i].addr);
        check($sformatf("vec%0d_rd_owner", i), 32'(so0), 32'(vecs[i].m));
        check($sformatf("vec%0d_rdata", i), rd0, vecs[i].data);
        if (ok0) exp_rd[vecs[i].m]++;
      end
    end

    // Concurrent m0 write and m1 read.
    seen = 1'b0;
    fork
      do_wr(0, 32'h40, 32'h4040_4040, 0, sa0, so0, t0, ok0);
      do_rd(1, 32'h44, sa1, so1, rd0, ok1);
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (wr_busy && rd_busy) begin
            check("conc_wr_owner", 32'(wr_owner), 32'd0);
            check("conc_rd_owner", 32'(rd_owner), 32'd1);
            seen = 1'b1;
            break;
          end
        end
      end
    join
    check("conc_overlap", 32'(seen), 32'd1);
    check("conc_wr_done", 32'(ok0), 32'd1);
    check("conc_rdata", rd0, 32'hCAFE_0044);
    if (ok0) exp_wr[0]++;
    if (ok1) exp_rd[1]++;
    do_rd(1, 32'h40, sa1, so1, rd0, ok1);
    check("conc_readback", rd0, 32'h4040_4040);
    if (ok1) exp_rd[1]++;

    // Reset while the write FSM waits in the data phase.
    seen = 1'b0;
    @(posedge clk); #1;
    m_awaddr[0] = 32'h58; m_awvalid[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_awready[0]) begin seen = 1'b1; break; end
    end
    check("rstmid_aw", 32'(seen), 32'd1);
    @(posedge clk); #1;
    m_awvalid[0] = 1'b0;
    @(negedge clk);
    check("rstmid_in_dat", 32'(wr_busy), 32'd1);
    check("rstmid_no_wvalid", 32'(s_wvalid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_wr[0] = 0; exp_wr[1] = 0; exp_rd[0] = 0; exp_rd[1] = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_wr_busy",   32'(wr_busy),   32'd0);
    check("rstmid_s_awvalid", 32'(s_awvalid), 32'd0);
    check("rstmid_s_wvalid",  32'(s_wvalid),  32'd0);
    check("rstmid_s_arvalid", 32'(s_arvalid), 32'd0);
    check("rstmid_s_awaddr",  s_awaddr,       32'd0);
    do_wr(0, 32'h50, 32'h5555_AAAA, 0, sa0, so0, t0, ok0);
    check("post_rst_wr_done", 32'(ok0), 32'd1);
    if (ok0) exp_wr[0]++;
    do_rd(1, 32'h50, sa1, so1, rd0, ok1);
    check("post_rst_rdata", rd0, 32'h5555_AAAA);
    if (ok1) exp_rd[1]++;

    check("isolation_errors", 32'(iso_err), 32'd0);

`ifdef AXI_ARB_STATS_EN
    check("m0_wr_cnt", 32'(m0_wr_cnt), 32'(exp_wr[0]));
    check("m1_wr_cnt", 32'(m1_wr_cnt), 32'(exp_wr[1]));
    check("m0_rd_cnt", 32'(m0_rd_cnt), 32'(exp_rd[0]));
    check("m1_rd_cnt", 32'(m1_rd_cnt), 32'(exp_rd[1]));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
